// File: rtl/guess_eval_sequencer.sv
// Scores one snapshotted guess against the secret (serial green pass, then serial
// yellow pass) and commits the guess pins plus both hint counts to the board RAM.
module guess_eval_sequencer #(
  parameter int MAX_PINS     = 20,
  parameter int COLOR_W      = 5,
  parameter int POS_W        = 5,
  parameter int MAX_GUESSES  = 99,
  parameter int ADDR_W       = 12,
  parameter int HINTS_OFFSET = 1980
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [POS_W-1:0]             pins_count,
  input  logic [7:0]                   guess_row,
  input  logic [MAX_PINS*COLOR_W-1:0]  guess_flat,
  input  logic [MAX_PINS*COLOR_W-1:0]  secret_flat,
  output logic                         busy,
  output logic                         done,
  output logic [POS_W-1:0]             green,
  output logic [POS_W-1:0]             yellow,
  output logic                         win,
  output logic                         err,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [COLOR_W-1:0]           ram_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_GREEN, S_YELLOW, S_WR_GUESS, S_WR_HG, S_WR_HY, S_DONE
  } state_t;

  localparam logic [POS_W-1:0]  ONE_P   = POS_W'(1);
  localparam logic [POS_W-1:0]  MAX_P   = POS_W'(MAX_PINS);
  localparam logic [7:0]        ROW_LIM = 8'(MAX_GUESSES);
  localparam logic [ADDR_W-1:0] PINS_A  = ADDR_W'(MAX_PINS);
  localparam logic [ADDR_W-1:0] HINT_A  = ADDR_W'(HINTS_OFFSET);

  state_t                state_q, state_d;
  logic [COLOR_W-1:0]    guess_q  [MAX_PINS];
  logic [COLOR_W-1:0]    guess_d  [MAX_PINS];
  logic [COLOR_W-1:0]    secret_q [MAX_PINS];
  logic [COLOR_W-1:0]    secret_d [MAX_PINS];
  logic [7:0]            row_q, row_d;
  logic [POS_W-1:0]      pinCnt_q, pinCnt_d;
  logic [POS_W-1:0]      idxI_q, idxI_d;
  logic [POS_W-1:0]      idxJ_q, idxJ_d;
  logic [POS_W-1:0]      wrIdx_q, wrIdx_d;
  logic [MAX_PINS-1:0]   agMask_q, agMask_d;
  logic [MAX_PINS-1:0]   asMask_q, asMask_d;
  logic [POS_W-1:0]      green_q, green_d;
  logic [POS_W-1:0]      yellow_q, yellow_d;
  logic                  win_q, win_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ramWe_q, ramWe_d;
  logic [ADDR_W-1:0]     ramAddr_q, ramAddr_d;
  logic [COLOR_W-1:0]    ramWdata_q, ramWdata_d;

  logic [POS_W-1:0]      lastIdx;
  logic [ADDR_W-1:0]     rowA;
  logic                  advI;
  logic                  scoreDone;

  assign lastIdx = pinCnt_q - ONE_P;
  assign rowA    = ADDR_W'(row_q);

  // Next-state logic; RAM strobes and status flags are derived from the next
  // state so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    secret_d   = secret_q;
    row_d      = row_q;
    pinCnt_d   = pinCnt_q;
    idxI_d     = idxI_q;
    idxJ_d     = idxJ_q;
    wrIdx_d    = wrIdx_q;
    agMask_d   = agMask_q;
    asMask_d   = asMask_q;
    green_d    = green_q;
    yellow_d   = yellow_q;
    win_d      = win_q;
    err_d      = err_q;
    advI       = 1'b0;
    scoreDone  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int p = 0; p < MAX_PINS; p++) begin
            guess_d[p]  = guess_flat[p*COLOR_W +: COLOR_W];
            secret_d[p] = secret_flat[p*COLOR_W +: COLOR_W];
          end
          row_d    = guess_row;
          pinCnt_d = (pins_count > MAX_P) ? MAX_P : pins_count;
          green_d  = '0;
          yellow_d = '0;
          win_d    = 1'b0;
          err_d    = 1'b0;
          agMask_d = '0;
          asMask_d = '0;
          idxI_d   = '0;
          idxJ_d   = '0;
          state_d  = S_GREEN;
        end
      end
      S_GREEN: begin
        if (pinCnt_q == '0) begin
          scoreDone = 1'b1;
        end else begin
          if (guess_q[idxI_q] == secret_q[idxI_q]) begin
            green_d          = green_q + ONE_P;
            agMask_d[idxI_q] = 1'b1;
            asMask_d[idxI_q] = 1'b1;
          end
          if (idxI_q == lastIdx) begin
            idxI_d  = '0;
            idxJ_d  = '0;
            state_d = S_YELLOW;
          end else begin
            idxI_d = idxI_q + ONE_P;
          end
        end
      end
      S_YELLOW: begin
        // A secret pin already claimed by a green or earlier yellow cannot match twice.
        if (agMask_q[idxI_q]) begin
          advI = 1'b1;
        end else if (!asMask_q[idxJ_q] && (guess_q[idxI_q] == secret_q[idxJ_q])) begin
          yellow_d         = yellow_q + ONE_P;
          agMask_d[idxI_q] = 1'b1;
          asMask_d[idxJ_q] = 1'b1;
          advI             = 1'b1;
        end else if (idxJ_q == lastIdx) begin
          advI = 1'b1;
        end else begin
          idxJ_d = idxJ_q + ONE_P;
        end
        if (advI) begin
          idxJ_d = '0;
          if (idxI_q == lastIdx) scoreDone = 1'b1;
          else                   idxI_d    = idxI_q + ONE_P;
        end
      end
      S_WR_GUESS: begin
        if (wrIdx_q == lastIdx) state_d = S_WR_HG;
        else                    wrIdx_d = wrIdx_q + ONE_P;
      end
      S_WR_HG:  state_d = S_WR_HY;
      S_WR_HY:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // An out-of-range row still gets scored but never touches the RAM.
    if (scoreDone) begin
      wrIdx_d = '0;
      if (row_q >= ROW_LIM) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else if (pinCnt_q == '0) begin
        state_d = S_WR_HG;
      end else begin
        state_d = S_WR_GUESS;
      end
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE) win_d = (green_q == pinCnt_q) && (pinCnt_q != '0);

    ramWe_d    = 1'b0;
    ramAddr_d  = '0;
    ramWdata_d = '0;
    case (state_d)
      S_WR_GUESS: begin
        ramWe_d    = 1'b1;
        ramAddr_d  = rowA * PINS_A + ADDR_W'(wrIdx_d);
        ramWdata_d = guess_q[wrIdx_d];
      end
      S_WR_HG: begin
        ramWe_d    = 1'b1;
        ramAddr_d  = HINT_A + rowA + rowA;
        ramWdata_d = COLOR_W'(green_d);
      end
      S_WR_HY: begin
        ramWe_d    = 1'b1;
        ramAddr_d  = HINT_A + rowA + rowA + ADDR_W'(1);
        ramWdata_d = COLOR_W'(yellow_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int p = 0; p < MAX_PINS; p++) begin
        guess_q[p]  <= '0;
        secret_q[p] <= '0;
      end
      row_q      <= '0;
      pinCnt_q   <= '0;
      idxI_q     <= '0;
      idxJ_q     <= '0;
      wrIdx_q    <= '0;
      agMask_q   <= '0;
      asMask_q   <= '0;
      green_q    <= '0;
      yellow_q   <= '0;
      win_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ramWe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      secret_q   <= secret_d;
      row_q      <= row_d;
      pinCnt_q   <= pinCnt_d;
      idxI_q     <= idxI_d;
      idxJ_q     <= idxJ_d;
      wrIdx_q    <= wrIdx_d;
      agMask_q   <= agMask_d;
      asMask_q   <= asMask_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      win_q      <= win_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ramWe_q    <= ramWe_d;
      ramAddr_q  <= ramAddr_d;
      ramWdata_q <= ramWdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign green     = green_q;
  assign yellow    = yellow_q;
  assign win       = win_q;
  assign err       = err_q;
  assign ram_we    = ramWe_q;
  assign ram_addr  = ramAddr_q;
  assign ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_guess_eval_sequencer.sv
// Directed bench for guess_eval_sequencer: hand-computed scores, RAM write
// sequences, cycle counts, control corner cases and a mid-run reset.
module tb_guess_eval_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   pins_count;
  logic [7:0]   guess_row;
  logic [99:0]  guess_flat;
  logic [99:0]  secret_flat;
  logic         busy, done, win, err, ram_we;
  logic [4:0]   green, yellow, ram_wdata;
  logic [11:0]  ram_addr;

  int errors = 0;
  int checks = 0;
  int wrAddr[$];
  int wrData[$];
  int busyCycles;
  logic sawDone;

  guess_eval_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pins_count(pins_count),
    .guess_row(guess_row), .guess_flat(guess_flat), .secret_flat(secret_flat),
    .busy(busy), .done(done), .green(green), .yellow(yellow), .win(win),
    .err(err), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [99:0] pack4(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
    logic [99:0] f;
    f = '0;
    f[4:0]   = a;
    f[9:5]   = b;
    f[14:10] = c;
    f[19:15] = d;
    return f;
  endfunction

  function automatic logic [99:0] fill20(input logic [4:0] v);
    logic [99:0] f;
    for (int p = 0; p < 20; p++) f[p*5 +: 5] = v;
    return f;
  endfunction

  function automatic int wrA(input int idx);
    return (idx < wrAddr.size()) ? wrAddr[idx] : -1;
  endfunction

  function automatic int wrD(input int idx);
    return (idx < wrData.size()) ? wrData[idx] : -1;
  endfunction

  // Issues one start, then records RAM writes and busy cycles until done (bounded).
  task automatic applyStimulus(input logic [4:0] cnt, input logic [7:0] row,
                               input logic [99:0] g, input logic [99:0] s, input bit interfere);
    int cycles;
    @(negedge clk);
    wrAddr.delete();
    wrData.delete();
    busyCycles  = 0;
    pins_count  = cnt;
    guess_row   = row;
    guess_flat  = g;
    secret_flat = s;
    start       = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      if (ram_we) begin
        wrAddr.push_back(int'(ram_addr));
        wrData.push_back(int'(ram_wdata));
      end
      if (busy) busyCycles++;
      if (interfere && cycles == 2) begin
        start      = 1'b1;
        pins_count = 5'd1;
        guess_flat = fill20(5'd9);
      end
      if (interfere && cycles == 3) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    sawDone = done;
    checkOutput("done_seen", sawDone, 1);
  endtask

  initial begin
    int cycles;
    reset = 1'b1; start = 1'b0; pins_count = '0; guess_row = '0;
    guess_flat = '0; secret_flat = '0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_green", green, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Exact match, row 3
    applyStimulus(5'd4, 8'd3, pack4(1,2,3,4), pack4(1,2,3,4), 1'b0);
    checkOutput("exact_green", green, 4);
    checkOutput("exact_yellow", yellow, 0);
    checkOutput("exact_win", win, 1);
    checkOutput("exact_err", err, 0);
    checkOutput("exact_busy_cycles", busyCycles, 14);
    checkOutput("exact_nwrites", wrAddr.size(), 6);
    for (int k = 0; k < 4; k++) begin
      checkOutput("exact_wr_addr", wrA(k), 60 + k);
      checkOutput("exact_wr_data", wrD(k), k + 1);
    end
    checkOutput("exact_hg_addr", wrA(4), 1986);
    checkOutput("exact_hg_data", wrD(4), 4);
    checkOutput("exact_hy_addr", wrA(5), 1987);
    checkOutput("exact_hy_data", wrD(5), 0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("green_held", green, 4);

    // Colour-only matches
    applyStimulus(5'd4, 8'd0, pack4(2,1,3,5), pack4(1,2,3,4), 1'b0);
    checkOutput("colour_green", green, 1);
    checkOutput("colour_yellow", yellow, 2);
    checkOutput("colour_win", win, 0);
    checkOutput("colour_busy_cycles", busyCycles, 18);

    // Duplicates
    applyStimulus(5'd4, 8'd1, pack4(2,2,0,0), pack4(0,2,1,1), 1'b0);
    checkOutput("dup1_green", green, 1);
    checkOutput("dup1_yellow", yellow, 1);
    applyStimulus(5'd4, 8'd1, pack4(1,1,1,1), pack4(1,2,1,3), 1'b0);
    checkOutput("dup2_green", green, 2);
    checkOutput("dup2_yellow", yellow, 0);

    // Last valid row, full width, nothing matches
    applyStimulus(5'd20, 8'd98, fill20(5'd2), fill20(5'd1), 1'b0);
    checkOutput("big_busy_cycles", busyCycles, 442);
    checkOutput("big_nwrites", wrAddr.size(), 22);
    checkOutput("big_first_addr", wrA(0), 1960);
    checkOutput("big_first_data", wrD(0), 2);
    checkOutput("big_pin19_addr", wrA(19), 1979);
    checkOutput("big_hg_addr", wrA(20), 2176);
    checkOutput("big_hg_data", wrD(20), 0);
    checkOutput("big_hy_addr", wrA(21), 2177);
    checkOutput("big_hy_data", wrD(21), 0);
    checkOutput("big_win", win, 0);

    // Out-of-range row
    applyStimulus(5'd4, 8'd99, pack4(1,2,3,4), pack4(1,2,3,4), 1'b0);
    checkOutput("badrow_err", err, 1);
    checkOutput("badrow_nwrites", wrAddr.size(), 0);
    checkOutput("badrow_green", green, 4);
    checkOutput("badrow_busy_cycles", busyCycles, 8);

    // Start while busy is ignored and the snapshot is kept
    applyStimulus(5'd4, 8'd2, pack4(1,2,3,4), pack4(1,2,3,4), 1'b1);
    checkOutput("ign_green", green, 4);
    checkOutput("ign_err_cleared", err, 0);
    checkOutput("ign_busy_cycles", busyCycles, 14);
    checkOutput("ign_nwrites", wrAddr.size(), 6);
    checkOutput("ign_wr0_addr", wrA(0), 40);
    checkOutput("ign_wr0_data", wrD(0), 1);

    // Reset in the middle of the guess writes
    @(negedge clk);
    pins_count = 5'd4; guess_row = 8'd3;
    guess_flat = pack4(1,2,3,4); secret_flat = pack4(1,2,3,4);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!ram_we && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("mid_reached_wr", ram_we, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_ram_we", ram_we, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_green", green, 0);
    @(negedge clk);
    reset = 1'b0;

    // Clamped pin count after the reset
    applyStimulus(5'd25, 8'd1, fill20(5'd3), fill20(5'd3), 1'b0);
    checkOutput("clamp_green", green, 20);
    checkOutput("clamp_yellow", yellow, 0);
    checkOutput("clamp_win", win, 1);
    checkOutput("clamp_busy_cycles", busyCycles, 62);
    checkOutput("clamp_nwrites", wrAddr.size(), 22);
    checkOutput("clamp_hg_addr", wrA(20), 1982);
    checkOutput("clamp_hg_data", wrD(20), 20);
    checkOutput("clamp_hy_addr", wrA(21), 1983);

    // Zero pins: only the hint writes
    applyStimulus(5'd0, 8'd5, pack4(1,2,3,4), pack4(1,2,3,4), 1'b0);
    checkOutput("zero_nwrites", wrAddr.size(), 2);
    checkOutput("zero_hg_addr", wrA(0), 1990);
    checkOutput("zero_hg_data", wrD(0), 0);
    checkOutput("zero_hy_addr", wrA(1), 1991);
    checkOutput("zero_hy_data", wrD(1), 0);
    checkOutput("zero_win", win, 0);
    checkOutput("zero_busy_cycles", busyCycles, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_eval_sequencer.md
Name: guess_eval_sequencer

Overview:
Sequencer that scores one entered guess against the secret and commits the result to board RAM. On `start` it snapshots the guess, secret, pin count and row. It then runs a serial green pass and a serial yellow pass, writes the guess pins and the two hint counts into the shared board RAM, and pulses `done`. It sits between the game-state FSM (which raises `start` on guess-entered) and the single-port board RAM. It is the only RAM writer while `busy`=1.

Parameters:
MAX_PINS, 20, pins per row and row stride in RAM
COLOR_W, 5, bits per pin colour; also the RAM data width
POS_W, 5, bits for pin index, pin count and hint counts
MAX_GUESSES, 99, number of valid rows
ADDR_W, 12, RAM address width
HINTS_OFFSET, 1980, base address of the hint area (MAX_PINS*MAX_GUESSES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-high
start  in  1  single-cycle request; sampled only in IDLE
pins_count  in  POS_W  active pins for this guess
guess_row  in  8  row index being committed
guess_flat  in  MAX_PINS*COLOR_W  pin i at bits [i*COLOR_W +: COLOR_W]
secret_flat  in  MAX_PINS*COLOR_W  same packing as guess_flat
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
green  out  POS_W  exact-position matches; held until the next accepted start
yellow  out  POS_W  colour-only matches; held until the next accepted start
win  out  1  green==n and n!=0; held with green
err  out  1  row out of range on the last run; held
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  COLOR_W  RAM write data

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. Analysis masks and counters cleared. An in-flight run is abandoned with no further RAM writes; partial writes already made are not undone.
- States: IDLE -> GREEN -> YELLOW -> WR_GUESS -> WR_HG -> WR_HY -> DONE -> IDLE.
- IDLE, when start=1:
  - Latch guess, secret and row.
  - Set n = min(pins_count, MAX_PINS).
  - Clear green, yellow, win, err and both masks (ag and as, MAX_PINS bits each).
  - Set i=j=0 and go to GREEN.
- start is ignored outside IDLE.
- GREEN: one pin per cycle, i=0..n-1.
  - If g[i]==s[i]: green+1, set ag[i] and as[i].
  - After i=n-1, go to YELLOW with i=j=0.
  - If n==0, GREEN takes 1 cycle and YELLOW is skipped.
- YELLOW: one (i,j) pair per cycle.
  - If ag[i]: advance i, set j=0.
  - Else if !as[j] and g[i]==s[j]: yellow+1, set ag[i] and as[j], advance i, set j=0.
  - Else if j==n-1: advance i, set j=0.
  - Else: j+1.
  - When i advances past n-1, go to WR_GUESS.
  - Worst case n*n cycles.
- Row check at WR_GUESS entry: if guess_row >= MAX_GUESSES, set err=1, issue no writes, jump to DONE.
- WR_GUESS: n cycles with ram_we=1, ram_addr = row*MAX_PINS + k, ram_wdata = g[k], for k=0..n-1.
- WR_HG: one write, addr = HINTS_OFFSET + 2*row, data = green.
- WR_HY: one write, addr = HINTS_OFFSET + 2*row + 1, data = yellow.
- ram_we=0 in every other state. All address arithmetic is unsigned at ADDR_W bits.
- DONE: done=1 for one cycle, busy=0 in the same cycle, win registered. Then IDLE; a new start may be accepted on the next cycle.
- Latency for n>0 and a valid row: the start cycle (IDLE) is followed by n GREEN cycles, Y YELLOW cycles, n WR_GUESS cycles, 2 hint-write cycles and 1 DONE cycle.
- Inputs are snapshotted, so changes to guess_flat or secret_flat after start do not affect the run.
- Counts never exceed n. No counter wraps.

Test Plan:
- Exact match: n=4, secret {1,2,3,4}, guess {1,2,3,4}, row 3 -> green=4, yellow=0, win=1. Writes addr 60..63 = 1,2,3,4, then 1986=4, 1987=0.
- Colour-only matches: secret {1,2,3,4}, guess {2,1,3,5} -> green=1, yellow=2, win=0.
- Duplicates: secret {0,2,1,1}, guess {2,2,0,0} -> green=1, yellow=1. Guess {1,1,1,1} vs secret {1,2,1,3} -> green=2, yellow=0.
- Boundary row and size: row 98, n=20 all mismatched -> 400 YELLOW cycles, 22 writes, last two at addr 2176=0 and 2177=0. Row 99 -> err=1, zero writes, done pulses.
- Control: start while busy is ignored, and green is unchanged at done. Reset asserted mid-WR_GUESS -> ram_we falls immediately, busy=0, the next start runs normally. pins_count=25 is clamped to 20. pins_count=0 -> only hint writes (0,0), win=0.
